// File: rtl/lsu_arbiter.sv
// Two-port arbiter and single-path access sequencer in front of the load/store unit.
// Port 0 is the pipeline MEM stage, port 1 is the debug/DMA master; each accepted request gets one LSU cycle.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | no command held, ready to accept
// S_ACCESS | latched command drives the LSU for exactly one cycle
// S_RESP   | response registered and presented; may accept the next request
module lsu_arbiter #(
   parameter int LOCK_MAX = 8
) (
   input  logic        i_clk,
   input  logic        i_reset_n,

   input  logic        i_p0_valid,
   output logic        o_p0_ready,
   input  logic        i_p0_wren,
   input  logic [31:0] i_p0_addr,
   input  logic [31:0] i_p0_wdata,
   input  logic [2:0]  i_p0_slt,
   output logic        o_p0_rvalid,
   output logic [31:0] o_p0_rdata,
   output logic        o_p0_err,
   input  logic        i_p0_lock,

   input  logic        i_p1_valid,
   output logic        o_p1_ready,
   input  logic        i_p1_wren,
   input  logic [31:0] i_p1_addr,
   input  logic [31:0] i_p1_wdata,
   input  logic [2:0]  i_p1_slt,
   output logic        o_p1_rvalid,
   output logic [31:0] o_p1_rdata,
   output logic        o_p1_err,

   output logic        o_lsu_wren,
   output logic [31:0] o_lsu_addr,
   output logic [31:0] o_st_data,
   output logic [2:0]  o_slt_sl,
   input  logic [31:0] i_ld_data
);

   localparam int CW = $clog2(LOCK_MAX + 1);
   localparam logic [CW-1:0] LOCK_MAX_C = CW'(LOCK_MAX);

   localparam logic [2:0] SLT_SB  = 3'b000;
   localparam logic [2:0] SLT_SH  = 3'b001;
   localparam logic [2:0] SLT_SW  = 3'b010;
   localparam logic [2:0] SLT_LH  = 3'b100;
   localparam logic [2:0] SLT_LW  = 3'b101;
   localparam logic [2:0] SLT_LHU = 3'b111;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_RESP   = 2'd2
   } state_t;

   state_t state, state_nxt;

   logic          rr;
   logic          last_p0;
   logic [CW-1:0] lock_cnt;

   logic          cmd_port;
   logic          cmd_wren;
   logic [31:0]   cmd_addr;
   logic [31:0]   cmd_wdata;
   logic [2:0]    cmd_slt;
   logic          cmd_err;

   logic          can_accept;
   logic          lock_win;
   logic          pick1;
   logic          grant0;
   logic          grant1;
   logic          accept;
   logic          sel_wren;
   logic [31:0]   sel_addr;
   logic [31:0]   sel_wdata;
   logic [2:0]    sel_slt;
   logic          sel_err;
   logic          load_ok;

   // Rejects anything outside the memory map, stores to the read-only switch
   // window, wren/slt class disagreement and misaligned half/word accesses.
   function automatic logic req_err(input logic wren, input logic [31:0] addr,
                                    input logic [2:0] slt);
      logic sw_region;
      logic legal;
      logic store_type;
      logic misal;
      sw_region  = (addr[31:12] == 20'h10010);
      legal      = (addr[31:16] == 16'h0000) ||
                   ((addr >= 32'h1000_0000) && (addr <= 32'h1000_4FFF)) ||
                   sw_region;
      store_type = (slt == SLT_SB) || (slt == SLT_SH) || (slt == SLT_SW);
      misal      = (((slt == SLT_SW) || (slt == SLT_LW)) && (addr[1:0] != 2'b00)) ||
                   (((slt == SLT_SH) || (slt == SLT_LH) || (slt == SLT_LHU)) && addr[0]);
      return !legal || (sw_region && wren) || (wren != store_type) || misal;
   endfunction

   // Arbitration: lock keeps port 0 in charge for up to LOCK_MAX contended grants.
   always_comb begin
      can_accept = (state == S_IDLE) || (state == S_RESP);
      lock_win   = last_p0 && i_p0_lock && (lock_cnt < LOCK_MAX_C);
      pick1      = i_p1_valid && (!i_p0_valid || (rr && !lock_win));
      grant0     = can_accept && i_p0_valid && !pick1;
      grant1     = can_accept && pick1;
      accept     = grant0 || grant1;
      sel_wren   = pick1 ? i_p1_wren  : i_p0_wren;
      sel_addr   = pick1 ? i_p1_addr  : i_p0_addr;
      sel_wdata  = pick1 ? i_p1_wdata : i_p0_wdata;
      sel_slt    = pick1 ? i_p1_slt   : i_p0_slt;
      sel_err    = req_err(sel_wren, sel_addr, sel_slt);
   end

   assign o_p0_ready = grant0;
   assign o_p1_ready = grant1;

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:   if (accept) state_nxt = S_ACCESS;
         S_ACCESS: state_nxt = S_RESP;
         S_RESP:   state_nxt = accept ? S_ACCESS : S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         rr       <= 1'b0;
         last_p0  <= 1'b0;
         lock_cnt <= '0;
      end else begin
         if (grant0) begin
            rr      <= 1'b1;
            last_p0 <= 1'b1;
         end else if (grant1) begin
            rr      <= 1'b0;
            last_p0 <= 1'b0;
         end
         if (!i_p0_lock || grant1) begin
            lock_cnt <= '0;
         end else if (grant0 && i_p1_valid && (lock_cnt < LOCK_MAX_C)) begin
            lock_cnt <= lock_cnt + 1'b1;
         end
      end
   end

   // The command register doubles as the LSU output register, so the LSU
   // address/data/type hold their last values once ACCESS ends.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         cmd_port  <= 1'b0;
         cmd_wren  <= 1'b0;
         cmd_addr  <= '0;
         cmd_wdata <= '0;
         cmd_slt   <= '0;
         cmd_err   <= 1'b0;
      end else if (accept) begin
         cmd_port  <= pick1;
         cmd_wren  <= sel_wren;
         cmd_addr  <= sel_addr;
         cmd_wdata <= sel_wdata;
         cmd_slt   <= sel_slt;
         cmd_err   <= sel_err;
      end
   end

   assign o_lsu_wren = (state == S_ACCESS) && cmd_wren && !cmd_err;
   assign o_lsu_addr = cmd_addr;
   assign o_st_data  = cmd_wdata;
   assign o_slt_sl   = cmd_slt;

   assign load_ok = !cmd_err && !cmd_wren;

   // Per-port response flops are loaded only at the end of ACCESS and cleared
   // otherwise, so rdata/err are zero whenever rvalid is low.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         o_p0_rvalid <= 1'b0;
         o_p0_rdata  <= '0;
         o_p0_err    <= 1'b0;
         o_p1_rvalid <= 1'b0;
         o_p1_rdata  <= '0;
         o_p1_err    <= 1'b0;
      end else if (state == S_ACCESS) begin
         o_p0_rvalid <= !cmd_port;
         o_p0_rdata  <= (!cmd_port && load_ok) ? i_ld_data : 32'h0;
         o_p0_err    <= !cmd_port && cmd_err;
         o_p1_rvalid <= cmd_port;
         o_p1_rdata  <= (cmd_port && load_ok) ? i_ld_data : 32'h0;
         o_p1_err    <= cmd_port && cmd_err;
      end else begin
         o_p0_rvalid <= 1'b0;
         o_p0_rdata  <= '0;
         o_p0_err    <= 1'b0;
         o_p1_rvalid <= 1'b0;
         o_p1_rdata  <= '0;
         o_p1_err    <= 1'b0;
      end
   end

endmodule

// File: tb/tb_lsu_arbiter.sv
// Directed bench for lsu_arbiter: store/load path, round-robin, lock limit, error rejection, async reset.
// The LSU stub returns {16'hC0DE, addr[15:0]} unless a fixed load value is forced.
module tb_lsu_arbiter;

   logic        i_clk = 1'b0;
   logic        i_reset_n;
   logic        i_p0_valid, i_p0_wren, i_p0_lock;
   logic [31:0] i_p0_addr, i_p0_wdata;
   logic [2:0]  i_p0_slt;
   logic        o_p0_ready, o_p0_rvalid, o_p0_err;
   logic [31:0] o_p0_rdata;
   logic        i_p1_valid, i_p1_wren;
   logic [31:0] i_p1_addr, i_p1_wdata;
   logic [2:0]  i_p1_slt;
   logic        o_p1_ready, o_p1_rvalid, o_p1_err;
   logic [31:0] o_p1_rdata;
   logic        o_lsu_wren;
   logic [31:0] o_lsu_addr, o_st_data, i_ld_data;
   logic [2:0]  o_slt_sl;

   logic        ld_fix;
   logic [31:0] ld_val;
   int          checks = 0;
   int          failures = 0;

   localparam logic [2:0] SB = 3'b000, SW = 3'b010, LB = 3'b011, LW = 3'b101;

   assign i_ld_data = ld_fix ? ld_val : {16'hC0DE, o_lsu_addr[15:0]};

   always #5 i_clk = ~i_clk;

   lsu_arbiter #(.LOCK_MAX(8)) dut (
      .i_clk(i_clk), .i_reset_n(i_reset_n),
      .i_p0_valid(i_p0_valid), .o_p0_ready(o_p0_ready), .i_p0_wren(i_p0_wren),
      .i_p0_addr(i_p0_addr), .i_p0_wdata(i_p0_wdata), .i_p0_slt(i_p0_slt),
      .o_p0_rvalid(o_p0_rvalid), .o_p0_rdata(o_p0_rdata), .o_p0_err(o_p0_err),
      .i_p0_lock(i_p0_lock),
      .i_p1_valid(i_p1_valid), .o_p1_ready(o_p1_ready), .i_p1_wren(i_p1_wren),
      .i_p1_addr(i_p1_addr), .i_p1_wdata(i_p1_wdata), .i_p1_slt(i_p1_slt),
      .o_p1_rvalid(o_p1_rvalid), .o_p1_rdata(o_p1_rdata), .o_p1_err(o_p1_err),
      .o_lsu_wren(o_lsu_wren), .o_lsu_addr(o_lsu_addr), .o_st_data(o_st_data),
      .o_slt_sl(o_slt_sl), .i_ld_data(i_ld_data)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic do_reset();
      i_reset_n = 1'b0;
      tick();
      i_reset_n = 1'b1;
      tick();
   endtask

   task automatic p0_req(input logic wren, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [2:0] slt);
      i_p0_valid = 1'b1;
      i_p0_wren  = wren;
      i_p0_addr  = addr;
      i_p0_wdata = wdata;
      i_p0_slt   = slt;
   endtask

   // Single port-0 request expected to be rejected with err.
   task automatic err_case(input string tag, input logic wren, input logic [31:0] addr,
                           input logic [2:0] slt);
      p0_req(wren, addr, 32'hFFFF_FFFF, slt);
      #1;
      chk({tag, "_ready"}, 32'(o_p0_ready), 32'd1);
      tick();
      i_p0_valid = 1'b0;
      chk({tag, "_wren"}, 32'(o_lsu_wren), 32'd0);
      tick();
      chk({tag, "_rvalid"}, 32'(o_p0_rvalid), 32'd1);
      chk({tag, "_err"}, 32'(o_p0_err), 32'd1);
      chk({tag, "_rdata"}, o_p0_rdata, 32'h0);
      chk({tag, "_wren_resp"}, 32'(o_lsu_wren), 32'd0);
      tick();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      i_reset_n  = 1'b0;
      i_p0_valid = 1'b0; i_p0_wren = 1'b0; i_p0_addr = '0; i_p0_wdata = '0;
      i_p0_slt   = LW;   i_p0_lock = 1'b0;
      i_p1_valid = 1'b0; i_p1_wren = 1'b0; i_p1_addr = '0; i_p1_wdata = '0;
      i_p1_slt   = LW;
      ld_fix     = 1'b0; ld_val = '0;

      // Reset state
      #3;
      chk("rst_lsu_wren", 32'(o_lsu_wren), 32'd0);
      chk("rst_lsu_addr", o_lsu_addr, 32'h0);
      chk("rst_st_data", o_st_data, 32'h0);
      chk("rst_rvalid", {30'd0, o_p1_rvalid, o_p0_rvalid}, 32'd0);
      chk("rst_rdata", o_p0_rdata | o_p1_rdata, 32'h0);
      tick();
      i_reset_n = 1'b1;
      tick();

      // SW then LW at 0x10 on port 0
      p0_req(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, SW);
      #1;
      chk("sw_ready", 32'(o_p0_ready), 32'd1);
      tick();
      i_p0_valid = 1'b0;
      chk("sw_wren_access", 32'(o_lsu_wren), 32'd1);
      chk("sw_addr", o_lsu_addr, 32'h0000_0010);
      chk("sw_data", o_st_data, 32'hDEAD_BEEF);
      chk("sw_slt", 32'(o_slt_sl), 32'(SW));
      tick();
      chk("sw_wren_resp", 32'(o_lsu_wren), 32'd0);
      chk("sw_rvalid", 32'(o_p0_rvalid), 32'd1);
      chk("sw_err", 32'(o_p0_err), 32'd0);
      chk("sw_rdata", o_p0_rdata, 32'h0);
      ld_fix = 1'b1; ld_val = 32'hDEAD_BEEF;
      p0_req(1'b0, 32'h0000_0010, 32'h0, LW);
      #1;
      chk("lw_ready_in_resp", 32'(o_p0_ready), 32'd1);
      tick();
      i_p0_valid = 1'b0;
      chk("lw_wren_access", 32'(o_lsu_wren), 32'd0);
      chk("lw_rvalid_access", 32'(o_p0_rvalid), 32'd0);
      tick();
      chk("lw_rvalid", 32'(o_p0_rvalid), 32'd1);
      chk("lw_rdata", o_p0_rdata, 32'hDEAD_BEEF);
      chk("lw_err", 32'(o_p0_err), 32'd0);
      tick();
      chk("lw_rvalid_drop", 32'(o_p0_rvalid), 32'd0);
      chk("lw_rdata_drop", o_p0_rdata, 32'h0);
      ld_fix = 1'b0;

      // Round-robin with both ports continuously valid
      do_reset();
      p0_req(1'b0, 32'h0000_0100, 32'h0, LW);
      i_p1_valid = 1'b1; i_p1_wren = 1'b0; i_p1_addr = 32'h0000_0204; i_p1_slt = LW;
      #1;
      for (int k = 0; k < 4; k++) begin
         chk("rr_ready0", 32'(o_p0_ready), (k % 2 == 0) ? 32'd1 : 32'd0);
         chk("rr_ready1", 32'(o_p1_ready), (k % 2 == 1) ? 32'd1 : 32'd0);
         tick();
         chk("rr_ready_access", {30'd0, o_p1_ready, o_p0_ready}, 32'd0);
         tick();
         chk("rr_rvalid0", 32'(o_p0_rvalid), (k % 2 == 0) ? 32'd1 : 32'd0);
         chk("rr_rvalid1", 32'(o_p1_rvalid), (k % 2 == 1) ? 32'd1 : 32'd0);
         chk("rr_rdata", o_p0_rdata | o_p1_rdata,
             (k % 2 == 0) ? 32'hC0DE_0100 : 32'hC0DE_0204);
      end
      i_p0_valid = 1'b0; i_p1_valid = 1'b0;
      tick();

      // Lock: 8 port-0 grants, then port 1
      do_reset();
      p0_req(1'b0, 32'h0000_0000, 32'h0, LW);
      i_p0_lock  = 1'b1;
      i_p1_valid = 1'b1; i_p1_addr = 32'h0000_0004;
      #1;
      for (int g = 0; g < 9; g++) begin
         if (g == 8) chk("lock_cnt_max", 32'(dut.lock_cnt), 32'd8);
         chk("lock_ready0", 32'(o_p0_ready), (g < 8) ? 32'd1 : 32'd0);
         chk("lock_ready1", 32'(o_p1_ready), (g == 8) ? 32'd1 : 32'd0);
         tick();
         if (g < 8) tick();
      end
      chk("lock_cnt_clear", 32'(dut.lock_cnt), 32'd0);
      i_p0_valid = 1'b0; i_p1_valid = 1'b0; i_p0_lock = 1'b0;
      tick();
      chk("lock_p1_rvalid", 32'(o_p1_rvalid), 32'd1);
      tick();

      // Rejected requests
      ld_fix = 1'b1; ld_val = 32'h1234_5678;
      err_case("err_sw_misal", 1'b1, 32'h0000_0002, SW);
      err_case("err_sb_ro", 1'b1, 32'h1001_0000, SB);
      err_case("err_lw_map", 1'b0, 32'h2000_0000, LW);

      // Port 1 LB with sign-extended LSU data
      ld_val = 32'hFFFF_FF80;
      i_p1_valid = 1'b1; i_p1_wren = 1'b0; i_p1_addr = 32'h1000_0003; i_p1_slt = LB;
      #1;
      chk("lb_ready1", 32'(o_p1_ready), 32'd1);
      tick();
      i_p1_valid = 1'b0;
      chk("lb_addr", o_lsu_addr, 32'h1000_0003);
      tick();
      chk("lb_rvalid1", 32'(o_p1_rvalid), 32'd1);
      chk("lb_rvalid0", 32'(o_p0_rvalid), 32'd0);
      chk("lb_rdata", o_p1_rdata, 32'hFFFF_FF80);
      chk("lb_err", 32'(o_p1_err), 32'd0);
      tick();
      ld_fix = 1'b0;

      // Async reset during ACCESS of a store
      p0_req(1'b1, 32'h0000_0020, 32'h1234_5678, SW);
      tick();
      i_p0_valid = 1'b0;
      chk("rstmid_wren_before", 32'(o_lsu_wren), 32'd1);
      #2;
      i_reset_n = 1'b0;
      #1;
      chk("rstmid_wren", 32'(o_lsu_wren), 32'd0);
      chk("rstmid_addr", o_lsu_addr, 32'h0);
      chk("rstmid_data", o_st_data, 32'h0);
      tick();
      chk("rstmid_rvalid", {30'd0, o_p1_rvalid, o_p0_rvalid}, 32'd0);
      i_reset_n = 1'b1;
      tick();
      chk("rstmid_rvalid_after", {30'd0, o_p1_rvalid, o_p0_rvalid}, 32'd0);
      p0_req(1'b0, 32'h0000_0020, 32'h0, LW);
      #1;
      chk("post_rst_ready", 32'(o_p0_ready), 32'd1);
      tick();
      i_p0_valid = 1'b0;
      chk("post_rst_addr", o_lsu_addr, 32'h0000_0020);
      tick();
      chk("post_rst_rvalid", 32'(o_p0_rvalid), 32'd1);
      chk("post_rst_rdata", o_p0_rdata, 32'hC0DE_0020);
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
